// File: rtl/sha3_pkg.sv
// Shared Keccak state types and geometry for the SHA-3 datapath blocks.
// A state is a 5x5 grid of 64-bit lanes, indexed [row][col].
package sha3_pkg;

  localparam int ROWS  = 5;
  localparam int COLS  = 5;
  localparam int LANES = ROWS * COLS;

  typedef logic [63:0] lane_t;
  typedef lane_t [ROWS-1:0][COLS-1:0] state_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

  // Lane index is row*5 + col; any index outside 0..24 reads as zero.
  function automatic lane_t lane_at(input state_t s, input logic [4:0] idx);
    lane_at = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (idx == 5'(r * COLS + c)) lane_at = s[r][c];
      end
    end
  endfunction

endpackage

// File: rtl/sha3_state_slot.sv
// One buffered Keccak state: loads all 25 lanes on a strobe and
// returns the lane selected by a 5-bit read index.
module sha3_state_slot
  import sha3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  state_t     din,
  input  logic [4:0] rindex,
  output lane_t      lane
);

  state_t mem;

  // NOTE: the slot storage is reset as well, so a slot that has never been
  // loaded reads back zero rather than X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (load) begin
      mem <= din;
    end
  end

  assign lane = lane_at(mem, rindex);

endmodule

// File: rtl/sha3_state_serializer.sv
// Captures full Keccak states into a two-slot buffer and streams them out
// one lane per accepted transfer (ready/valid), row a first, col 0 first.
module sha3_state_serializer
  import sha3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  lane_t [COLS-1:0]  isa,
  input  lane_t [COLS-1:0]  isb,
  input  lane_t [COLS-1:0]  isc,
  input  lane_t [COLS-1:0]  isd,
  input  lane_t [COLS-1:0]  ise,
  input  logic              sample,
  input  logic              iready,
  output lane_t             olane,
  output logic              ovalid,
  output logic [4:0]        oindex,
  output logic              olast,
  output logic [1:0]        pending,
  output logic              overrun
);

  localparam logic [4:0] LAST_IDX = 5'(LANES - 1);

  ser_state_e state, state_nxt;
  logic       wr_ptr, wr_ptr_nxt;
  logic       rd_ptr, rd_ptr_nxt;
  logic [4:0] idx, idx_nxt;
  logic [1:0] pending_nxt;
  logic       overrun_nxt;

  logic   xfer, last_xfer, accept;
  state_t cap;
  lane_t  slot_lane [2];
  logic   slot_load [2];

  always_comb begin
    cap[0] = isa;
    cap[1] = isb;
    cap[2] = isc;
    cap[3] = isd;
    cap[4] = ise;
  end

  for (genvar s = 0; s < 2; s++) begin : g_slot
    assign slot_load[s] = accept && (wr_ptr == 1'(s));

    sha3_state_slot u_slot (
      .clk    (clk),
      .rst    (rst),
      .load   (slot_load[s]),
      .din    (cap),
      .rindex (idx),
      .lane   (slot_lane[s])
    );
  end

  // A full buffer still accepts a sample when the slot being read finishes
  // this cycle: that slot is the one the write pointer already points to.
  assign xfer      = ovalid && iready;
  assign last_xfer = xfer && (idx == LAST_IDX);
  assign accept    = sample && ((pending != 2'd2) || last_xfer);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    idx_nxt     = idx;
    overrun_nxt = overrun || (sample && !accept);
    pending_nxt = pending + 2'(accept) - 2'(last_xfer);

    if (accept)    wr_ptr_nxt = !wr_ptr;
    if (last_xfer) rd_ptr_nxt = !rd_ptr;
    if (xfer)      idx_nxt    = last_xfer ? 5'd0 : idx + 5'd1;

    unique case (state)
      ST_IDLE:   if (pending_nxt != 2'd0) state_nxt = ST_STREAM;
      ST_STREAM: if (pending_nxt == 2'd0) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      idx     <= 5'd0;
      pending <= 2'd0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      idx     <= idx_nxt;
      pending <= pending_nxt;
      overrun <= overrun_nxt;
    end
  end

  assign ovalid = (state == ST_STREAM);
  assign olane  = ovalid ? slot_lane[rd_ptr] : '0;
  assign oindex = ovalid ? idx : 5'd0;
  assign olast  = ovalid && (idx == LAST_IDX);

endmodule

// File: tb/tb_sha3_state_serializer.sv
// Scoreboard bench: a lane-queue model predicts every output each cycle;
// accepted samples push 25 expected lanes, transfers pop them.
module tb_sha3_state_serializer;
  import sha3_pkg::*;

  logic             clk = 1'b0;
  logic             rst, sample, iready;
  lane_t [COLS-1:0] isa, isb, isc, isd, ise;
  lane_t            olane;
  logic             ovalid, olast, overrun;
  logic [4:0]       oindex;
  logic [1:0]       pending;

  sha3_state_serializer dut (
    .clk(clk), .rst(rst),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(sample), .iready(iready),
    .olane(olane), .ovalid(ovalid), .oindex(oindex), .olast(olast),
    .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] idx;
    lane_t      lane;
  } exp_t;

  exp_t       q[$];
  logic [3:0] cur_tag = 4'hA;
  bit         m_ovr   = 1'b0;
  bit         chk_en  = 1'b0;
  int         xfer_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  function automatic lane_t mk_lane(input logic [3:0] tag, input int i);
    return {tag, 60'h0} | 64'(i);
  endfunction

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      isa[c] = mk_lane(cur_tag, 0 * 5 + c);
      isb[c] = mk_lane(cur_tag, 1 * 5 + c);
      isc[c] = mk_lane(cur_tag, 2 * 5 + c);
      isd[c] = mk_lane(cur_tag, 3 * 5 + c);
      ise[c] = mk_lane(cur_tag, 4 * 5 + c);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare against the model state after the last edge, then advance the
  // model with this cycle's inputs (which stay put until after the next edge).
  always @(negedge clk) begin
    int pend;
    bit mv, lx, acc;
    pend = (q.size() + 24) / 25;
    mv   = q.size() > 0;
    if (chk_en) begin
      check("ovalid", 64'(ovalid), 64'(mv));
      check("pending", 64'(pending), 64'(pend));
      check("overrun", 64'(overrun), 64'(m_ovr));
      if (mv) begin
        check("olane", olane, q[0].lane);
        check("oindex", 64'(oindex), 64'(q[0].idx));
        check("olast", 64'(olast), 64'(q[0].idx == 5'd24));
      end else begin
        check("olane_idle", olane, 64'h0);
        check("oindex_idle", 64'(oindex), 64'h0);
        check("olast_idle", 64'(olast), 64'h0);
      end
    end
    if (rst) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      lx  = mv && iready && (q[0].idx == 5'd24);
      acc = sample && ((pend < 2) || lx);
      if (mv && iready) begin
        void'(q.pop_front());
        xfer_cnt++;
      end
      if (sample && !acc) m_ovr = 1'b1;
      if (acc) begin
        for (int i = 0; i < LANES; i++) q.push_back('{idx: 5'(i), lane: mk_lane(cur_tag, i)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_sample(input logic [3:0] tag);
    cur_tag = tag;
    sample  = 1'b1;
    tick();
    sample  = 1'b0;
  endtask

  // Drain the scoreboard; optionally drive iready with the 1,0,0,1 pattern.
  task automatic drain(input int max_cycles, input bit toggle);
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k   = 0;
    while (q.size() != 0 && k < max_cycles) begin
      if (toggle) iready = pat[3 - (k % 4)];
      tick();
      k++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'h0);
    iready = 1'b1;
  endtask

  task automatic wait_qsize(input int n, input int max_cycles);
    int k;
    k = 0;
    while (q.size() != n && k < max_cycles) begin
      tick();
      k++;
    end
    check("wait_qsize", 64'(q.size()), 64'(n));
  endtask

  initial begin
    int base;
    rst = 1'b1; sample = 1'b0; iready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Single state, always ready.
    iready = 1'b1;
    base = xfer_cnt;
    do_sample(4'hA);
    drain(200, 1'b0);
    check("t1_xfers", 64'(xfer_cnt - base), 64'd25);

    // Single state under a stalling consumer.
    tick();
    base = xfer_cnt;
    do_sample(4'hA);
    drain(400, 1'b1);
    check("t2_xfers", 64'(xfer_cnt - base), 64'd25);

    // Two states three cycles apart, back to back on the output.
    tick();
    base = xfer_cnt;
    do_sample(4'hA);
    tick();
    tick();
    do_sample(4'hB);
    drain(200, 1'b0);
    check("t3_xfers", 64'(xfer_cnt - base), 64'd50);

    // Three samples into a stalled buffer: the third is dropped.
    tick();
    iready = 1'b0;
    base = xfer_cnt;
    do_sample(4'hA);
    tick();
    do_sample(4'hB);
    tick();
    do_sample(4'hC);
    tick();
    tick();
    check("t4_overrun", 64'(overrun), 64'h1);
    check("t4_pending", 64'(pending), 64'h2);
    iready = 1'b1;
    drain(200, 1'b0);
    check("t4_xfers", 64'(xfer_cnt - base), 64'd50);
    tick();
    check("t4_overrun_held", 64'(overrun), 64'h1);
    do_reset();

    // Full buffer; sample C lands in the slot freed by A's lane 24.
    iready = 1'b0;
    base = xfer_cnt;
    do_sample(4'hA);
    do_sample(4'hB);
    iready = 1'b1;
    wait_qsize(26, 100);
    do_sample(4'hC);
    drain(200, 1'b0);
    check("t5_xfers", 64'(xfer_cnt - base), 64'd75);
    check("t5_overrun", 64'(overrun), 64'h0);

    // Reset mid-stream with B pending; a coincident sample is ignored.
    tick();
    do_sample(4'hA);
    do_sample(4'hB);
    wait_qsize(40, 100);
    cur_tag = 4'hC;
    sample  = 1'b1;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    sample  = 1'b0;
    tick();
    check("t6_ovalid", 64'(ovalid), 64'h0);
    check("t6_pending", 64'(pending), 64'h0);
    base = xfer_cnt;
    do_sample(4'h5);
    drain(200, 1'b0);
    check("t6_xfers", 64'(xfer_cnt - base), 64'd25);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
